sw2_debounce: RTL
=================

Name: sw2_debounce

Overview:
- Input conditioning stage that sits directly upstream of the two-input and/or gate block.
- Takes two raw, bouncing, asynchronous switch signals from the experiment board.
- Drives clean, synchronised, debounced levels onto the gate's x1/x2 inputs.
- Also emits one-cycle edge pulses for LEDs and counters.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per channel (legal range 2..4).
- STABLE_CNT, 50000, consecutive cycles a new level must hold before it is accepted (1 ms at 50 MHz). Legal range 1..2^CNT_W-1.
- CNT_W, 16, width of each per-channel stability counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sw1_in  in  1  raw switch 1, asynchronous, may bounce.
- sw2_in  in  1  raw switch 2, asynchronous, may bounce.
- x1  out  1  debounced level of sw1_in; feeds gate input x1.
- x2  out  1  debounced level of sw2_in; feeds gate input x2.
- x1_rise  out  1  one-cycle pulse when x1 goes 0->1.
- x1_fall  out  1  one-cycle pulse when x1 goes 1->0.
- x2_rise  out  1  one-cycle pulse when x2 goes 0->1.
- x2_fall  out  1  one-cycle pulse when x2 goes 1->0.

Behaviour:
- Reset (rst_n low, asynchronous): all synchroniser flops, counters, x1, x2 and all pulse outputs go to 0 immediately and stay 0 while rst_n is low.
- Release is synchronous: first update on the first rising clk edge after rst_n goes high.
- The two channels are identical and independent; no shared state.
- Per channel, a SYNC_STAGES-deep flop chain produces s (synchronised switch level).
- Per-channel FSM with states IDLE and COUNT:
  - IDLE: s == x; counter held at 0. If s != x, go to COUNT with counter = 1; if STABLE_CNT == 1, accept immediately instead.
  - COUNT: if s == x (bounce back), return to IDLE with counter = 0 and no output change.
  - COUNT: if s != x and counter == STABLE_CNT-1, load x <= s, go to IDLE, counter = 0, and pulse rise or fall for exactly one cycle, registered together with the x update.
  - COUNT: otherwise, counter increments by 1.
- The counter never wraps: it is cleared on acceptance or bounce, so it never exceeds STABLE_CNT-1.
- Latency:
  - A clean step on sw*_in reaches x* after exactly SYNC_STAGES + STABLE_CNT rising edges.
  - The pulse is asserted in the same cycle that x* changes.
- Glitch rejection: any pulse on sw*_in shorter than STABLE_CNT cycles, measured at s, produces no change on x* and no pulse.
- Simultaneous events: both channels may change and pulse in the same cycle.
- Rise and fall pulses of the same channel are mutually exclusive.
- Reset mid-count discards the pending transition; after reset, x* = 0 regardless of the switch level. A held-high switch is then re-accepted after the full latency.
- Pulse outputs are registered and are never asserted on the cycle after reset release.

Optional Feature:
- Macro: DEBOUNCE_EDGE_EN.
- Defined: the four edge-pulse outputs behave as described above.
- Undefined:
  - Edge pulse registers are not built.
  - x1_rise, x1_fall, x2_rise and x2_fall remain in the port list but are tied to constant 0.
  - x1/x2 behaviour is unchanged.

Test Plan (SYNC_STAGES=2, STABLE_CNT=4, CNT_W=4, DEBOUNCE_EDGE_EN defined unless stated):
- Reset values: hold rst_n=0 with sw1_in=sw2_in=1 for 5 cycles -> x1=x2=0 and all pulses 0 throughout.
- Clean step: after reset, sw1_in 0->1 just before edge N -> x1=1 and x1_rise=1 at edge N+5 (6 edges); x1_rise=0 from the following edge; x2 stays 0.
- Bounce rejection: sw2_in high for 3 cycles, low for 1, then high steadily -> x2 stays 0 during the bounce, then rises 6 edges after the final 0->1, with exactly one x2_rise pulse.
- Both channels + fall: x1=x2=1 stable, drop sw1_in and sw2_in on the same edge -> x1 and x2 fall on the same cycle; x1_fall and x2_fall each pulse once; no rise pulses.
- Reset mid-count: sw1_in 0->1, assert rst_n=0 asynchronously 3 cycles later, release after 2 cycles with sw1_in still 1 -> x1=0 immediately on reset; x1 rises 6 edges after release; one x1_rise.
- Macro undefined: repeat the clean-step case -> x1 timing identical; all pulse outputs remain 0.

Source files
------------

// File: rtl/sw2_debounce.sv
// sw2_debounce: two-channel switch conditioner in front of the and/or gate block.
// Each raw switch goes through a SYNC_STAGES-deep synchroniser and then a small
// IDLE/COUNT debounce FSM. A new level is accepted only after it has been seen
// at the synchroniser output for STABLE_CNT consecutive rising edges.
// Optional macro DEBOUNCE_EDGE_EN builds the registered one-cycle rise/fall
// pulse outputs. Without the macro those four ports are tied to 0.
module sw2_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 50000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw1_in,
    input  logic sw2_in,
    output logic x1,
    output logic x2,
    output logic x1_rise,
    output logic x1_fall,
    output logic x2_rise,
    output logic x2_fall
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Final count value: reaching it while the new level still holds means
    // STABLE_CNT consecutive edges have been observed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [1:0] sw_raw;
    logic [1:0] x_all;
    logic [1:0] rise_all;
    logic [1:0] fall_all;

    assign sw_raw = {sw2_in, sw1_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;
            logic                   s;
            state_t                 state_q;
            state_t                 state_d;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       cnt_d;
            logic                   x_q;
            logic                   x_d;
            logic                   accept;

            assign s = sync_q[SYNC_STAGES-1];

            // Shift the raw switch into the synchroniser chain, oldest bit at the top.
            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw[gi]};
            end

            // Debounce FSM: count consecutive edges where s differs from x.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                accept  = 1'b0;
                case (state_q)
                    IDLE: begin
                        cnt_d = '0;
                        if (s != x_q) begin
                            if (STABLE_CNT == 1) begin
                                accept = 1'b1;
                            end else begin
                                state_d = COUNT;
                                cnt_d   = CNT_W'(1);
                            end
                        end
                    end
                    COUNT: begin
                        if (s == x_q) begin
                            // Bounced back before the level settled: drop it.
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            accept  = 1'b1;
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
                x_d = accept ? s : x_q;
            end

            // Synchroniser, FSM and debounced level registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q  <= '0;
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    x_q     <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    x_q     <= x_d;
                end
            end

            assign x_all[gi] = x_q;

`ifdef DEBOUNCE_EDGE_EN
            logic rise_q;
            logic rise_d;
            logic fall_q;
            logic fall_d;

            // Edge pulses are decided in the same cycle as the x update.
            always_comb begin
                rise_d = accept & s;
                fall_d = accept & ~s;
            end

            // Pulse registers, so each pulse lines up with the new x value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                end
            end

            assign rise_all[gi] = rise_q;
            assign fall_all[gi] = fall_q;
`else
            assign rise_all[gi] = 1'b0;
            assign fall_all[gi] = 1'b0;
`endif
        end
    endgenerate

    assign x1      = x_all[0];
    assign x2      = x_all[1];
    assign x1_rise = rise_all[0];
    assign x1_fall = fall_all[0];
    assign x2_rise = rise_all[1];
    assign x2_fall = fall_all[1];

endmodule
